pool_window_feeder: RTL and testbench
=====================================

POOL_WINDOW_FEEDER -- requirements
Module: pool_window_feeder

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the FP16 element width in bits.
REQ-002 The block SHALL have parameter size, default 4, giving the elements per 2x2 window; only 4 is legal.
REQ-003 The block SHALL have parameter IMG_WIDTH, default 8, giving pixels per row; it must be even and at least 2.
REQ-004 The block SHALL have parameter IMG_HEIGHT, default 8, giving rows per frame; it must be even and at least 2.
REQ-005 The block SHALL have one clock; reset is asynchronous and active-high. The ports are clk and reset.
REQ-006 The block SHALL have port clk, input, 1 bit: the single clock, rising-edge active.
REQ-007 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 The block SHALL have port in_valid, input, 1 bit: in_data holds a raster-order pixel.
REQ-009 The block SHALL have port in_data, input, DATA_WIDTH bits: FP16 pixel.
REQ-010 The block SHALL have port in_ready, output, 1 bit: the block accepts a pixel this cycle.
REQ-011 The block SHALL have port out_valid, output, 1 bit: x holds a complete 2x2 window.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the downstream averaging unit takes x this cycle.
REQ-013 The block SHALL have port x, output, DATA_WIDTH*size bits: packed window. [63:48]=top-left, [47:32]=top-right, [31:16]=bottom-left, [15:0]=bottom-right.
REQ-014 The block SHALL have port frame_last, output, 1 bit: the window on x is the last of the frame; valid only while out_valid is high.

Function
REQ-015 A pixel SHALL be accepted on a rising clk edge where in_valid and in_ready are both high.
REQ-016 in_ready SHALL be equal to !(out_valid && !out_ready), combinationally.
REQ-017 The block SHALL keep a column counter col (0..IMG_WIDTH-1) and a row counter row (0..IMG_HEIGHT-1), both advanced only on accept.
REQ-018 On accept, col SHALL increment; at IMG_WIDTH-1, col SHALL wrap to 0 and row SHALL increment.
REQ-019 On accept at row=IMG_HEIGHT-1 and col=IMG_WIDTH-1, both counters SHALL wrap to 0 with no idle cycle, so the next pixel starts a new frame.
REQ-020 On an even row, each accepted pixel SHALL be written to line buffer entry lb[col], which holds IMG_WIDTH x DATA_WIDTH bits.
REQ-021 Even rows SHALL produce no output.
REQ-022 On an odd row at an even col, the accepted pixel SHALL be stored in the bottom-left holding register bl.
REQ-023 On an odd row at an odd col, the accept edge SHALL load x with {lb[col-1], lb[col], bl, in_data} and set out_valid high.
REQ-024 Latency SHALL be 1 cycle: out_valid is high in the cycle after the completing pixel is accepted.
REQ-025 frame_last SHALL be loaded together with x; it is 1 only for the window completed at row=IMG_HEIGHT-1, col=IMG_WIDTH-1.
REQ-026 out_valid SHALL clear on a clk edge with out_ready high, unless a new window loads on that same edge; in that case out_valid stays high and x updates.
REQ-027 While out_valid is high and out_ready is low, x and frame_last SHALL hold stable and no pixel SHALL be accepted.
REQ-028 The window SHALL move through the block unchanged; no arithmetic is performed here, and averaging stays downstream.
REQ-029 When in_valid is low, counters, line buffer and bl SHALL hold.
REQ-030 Exactly (IMG_WIDTH/2)*(IMG_HEIGHT/2) windows SHALL be emitted per frame.

Reset
REQ-031 While reset is high, the block SHALL force col=0, row=0, out_valid=0, frame_last=0 and x=0 asynchronously.
REQ-032 Line buffer and bl contents SHALL be don't-care after reset; they are overwritten before use.
REQ-033 A reset mid-frame SHALL discard the partial frame; the first pixel accepted after release is row 0, col 0.
REQ-034 While reset is high, in_ready SHALL read 1, and no accept occurs.

Verification (IMG_WIDTH=4, IMG_HEIGHT=2, out_ready=1 unless stated)
REQ-035 Basic window test: stream row0 3C00,4000,4200,4400, then row1 4500,4600,4700,4800. Required: x=64'h3C00400045004600 with frame_last=0, then x=64'h4200440047004800 with frame_last=1, each appearing 1 cycle after the 6th and 8th accepts respectively.
REQ-036 Backpressure test: hold out_ready=0 after the first window. Required: in_ready=0, x stays 64'h3C00400045004600, and counters are frozen. On out_ready=1, the stream resumes with no lost or duplicated pixel.
REQ-037 Back-to-back frames test: stream two frames with continuous in_valid. Required: 4 windows in total; frame_last goes high on windows 2 and 4 only.
REQ-038 Mid-frame reset test: assert reset after 3 pixels, release, then stream the 8 REQ-035 pixels. Required: outputs are exactly as in REQ-035, and out_valid=0 during reset.
REQ-039 Idle-gap test: insert in_valid=0 bubbles between every pixel. Required: same two windows as REQ-035, and out_valid is never high on an even row.

Source files
------------

// File: rtl/pool_window_feeder_if.sv
// Pixel stream in, packed 2x2 window out; both directions use valid/ready.
// The feeder binds the slave modport, and the pixel source / window sink binds the master modport.
interface pool_window_feeder_if #(
  parameter int DATA_WIDTH = 16,
  parameter int size       = 4
);
  logic                         in_valid;
  logic [DATA_WIDTH-1:0]        in_data;
  logic                         in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [DATA_WIDTH*size-1:0]   x;
  logic                         frame_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, x, frame_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, x, frame_last
  );
endinterface

// File: rtl/pool_window_feeder.sv
// 2x2 pool window gatherer: even rows fill a line buffer, odd-row pixel pairs complete windows.
// A window is valid 1 cycle after its last pixel; a stalled window blocks pixel intake.
module pool_window_feeder #(
  parameter int DATA_WIDTH = 16,
  parameter int size       = 4,
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input logic                 clk,
  input logic                 reset,
  pool_window_feeder_if.slave s
);
  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam int XW = DATA_WIDTH * size;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [DATA_WIDTH-1:0] lb [IMG_WIDTH];
  logic [DATA_WIDTH-1:0] bl;
  logic                  accept;
  logic                  load_win;

  assign s.in_ready = !(s.out_valid && !s.out_ready);
  assign accept     = s.in_valid && s.in_ready;
  assign load_win   = accept && row[0] && col[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      col          <= '0;
      row          <= '0;
      s.out_valid  <= 1'b0;
      s.x          <= '0;
      s.frame_last <= 1'b0;
    end else begin
      // A new window on the same edge as a consume keeps out_valid high.
      if (load_win) begin
        s.out_valid  <= 1'b1;
        s.x          <= XW'({lb[col ^ CW'(1)], lb[col], bl, s.in_data});
        s.frame_last <= (row == ROW_LAST) && (col == COL_LAST);
      end else if (s.out_ready) begin
        s.out_valid  <= 1'b0;
      end

      if (accept) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + RW'(1);
        end else begin
          col <= col + CW'(1);
        end
      end
    end
  end

  // Storage is always overwritten before it is read, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept && !row[0])
      lb[col] <= s.in_data;
    if (accept && row[0] && !col[0])
      bl <= s.in_data;
  end
endmodule

// File: tb/tb_pool_window_feeder.sv
// Randomized and directed bench for pool_window_feeder (4x2 image) with a frame-array reference model.
module tb_pool_window_feeder;
  localparam int DW = 16;
  localparam int SZ = 4;
  localparam int W  = 4;
  localparam int H  = 2;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pool_window_feeder_if #(.DATA_WIDTH(DW), .size(SZ)) bus ();

  pool_window_feeder #(.DATA_WIDTH(DW), .size(SZ), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: pixels of the current frame indexed by raster position.
  logic [DW-1:0] frame_pix [W*H];
  int            pix_idx;
  logic [64:0]   exp_q [$];
  logic [64:0]   got_q [$];
  logic          exp_vld;
  logic          prev_stall;
  logic [63:0]   prev_x;
  logic          prev_fl;
  int            rdy_mode;

  logic [DW-1:0] basic_pix [8] = '{16'h3C00, 16'h4000, 16'h4200, 16'h4400,
                                   16'h4500, 16'h4600, 16'h4700, 16'h4800};
  localparam logic [63:0] WIN0 = 64'h3C00400045004600;
  localparam logic [63:0] WIN1 = 64'h4200440047004800;

  always @(negedge clk) begin
    logic [64:0] e;
    logic        completes;
    int          r, c;
    if (reset) begin
      chk("rst_out_valid",  {63'd0, bus.out_valid}, 64'd0);
      chk("rst_x",          bus.x, 64'd0);
      chk("rst_frame_last", {63'd0, bus.frame_last}, 64'd0);
      chk("rst_in_ready",   {63'd0, bus.in_ready}, 64'd1);
      pix_idx    = 0;
      exp_q.delete();
      exp_vld    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk("in_ready", {63'd0, bus.in_ready}, {63'd0, !(bus.out_valid && !bus.out_ready)});
      chk("out_valid", {63'd0, bus.out_valid}, {63'd0, exp_vld});
      if (prev_stall) begin
        chk("hold_x", bus.x, prev_x);
        chk("hold_frame_last", {63'd0, bus.frame_last}, {63'd0, prev_fl});
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_window", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          chk("win_x", bus.x, e[63:0]);
          chk("win_frame_last", {63'd0, bus.frame_last}, {63'd0, e[64]});
        end
        got_q.push_back({bus.frame_last, bus.x});
      end
      completes = 1'b0;
      if (bus.in_valid && bus.in_ready) begin
        frame_pix[pix_idx] = bus.in_data;
        r = pix_idx / W;
        c = pix_idx % W;
        if ((r % 2 == 1) && (c % 2 == 1)) begin
          exp_q.push_back({pix_idx == W*H-1, frame_pix[pix_idx-W-1], frame_pix[pix_idx-W],
                           frame_pix[pix_idx-1], frame_pix[pix_idx]});
          completes = 1'b1;
        end
        pix_idx = (pix_idx + 1) % (W*H);
      end
      exp_vld    = completes || (exp_vld && !bus.out_ready);
      prev_stall = bus.out_valid && !bus.out_ready;
      prev_x     = bus.x;
      prev_fl    = bus.frame_last;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = 1'($urandom_range(0, 1));
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic set_rdy(input int mode);
    rdy_mode = mode;
    bus.out_ready = (mode != 2);
  endtask

  // Presents one pixel until accepted; called at posedge+1.
  task automatic send(input logic [DW-1:0] pix);
    logic acc;
    bus.in_valid = 1'b1;
    bus.in_data  = pix;
    for (int t = 0; t < 200; t++) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) return;
    end
    chk("send_timeout", 64'd1, 64'd0);
  endtask

  task automatic idle(input int n);
    bus.in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_basic(input string tag);
    chk({tag, "_count"}, 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      chk({tag, "_w0"},  got_q[0][63:0], WIN0);
      chk({tag, "_fl0"}, {63'd0, got_q[0][64]}, 64'd0);
      chk({tag, "_w1"},  got_q[1][63:0], WIN1);
      chk({tag, "_fl1"}, {63'd0, got_q[1][64]}, 64'd1);
    end
  endtask

  initial begin
    reset        = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    set_rdy(0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Basic windows
    got_q.delete();
    for (int i = 0; i < 8; i++) send(basic_pix[i]);
    idle(4);
    check_basic("basic");

    // Backpressure on the first window
    got_q.delete();
    set_rdy(2);
    for (int i = 0; i < 6; i++) send(basic_pix[i]);
    bus.in_valid = 1'b1;
    bus.in_data  = basic_pix[6];
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_x", bus.x, WIN0);
      @(posedge clk);
      #1;
    end
    set_rdy(0);
    send(basic_pix[6]);
    send(basic_pix[7]);
    idle(4);
    check_basic("bp");

    // Back-to-back frames
    got_q.delete();
    for (int i = 0; i < 2*W*H; i++) send(16'($urandom_range(0, 65535)));
    idle(4);
    chk("b2b_count", 64'(got_q.size()), 64'd4);
    if (got_q.size() == 4)
      for (int i = 0; i < 4; i++)
        chk("b2b_fl", {63'd0, got_q[i][64]}, {63'd0, 1'(i % 2)});

    // Mid-frame reset
    for (int i = 0; i < 3; i++) send(basic_pix[i]);
    bus.in_valid = 1'b0;
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
    got_q.delete();
    idle(1);
    for (int i = 0; i < 8; i++) send(basic_pix[i]);
    idle(4);
    check_basic("mid_reset");

    // Idle bubbles between pixels
    got_q.delete();
    for (int i = 0; i < 8; i++) begin
      send(basic_pix[i]);
      idle($urandom_range(1, 3));
    end
    idle(4);
    check_basic("gap");

    // Random traffic with random backpressure
    got_q.delete();
    set_rdy(1);
    for (int i = 0; i < 6*W*H; i++) begin
      send(16'($urandom_range(0, 65535)));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    bus.in_valid = 1'b0;
    set_rdy(0);
    idle(6);
    chk("rand_count", 64'(got_q.size()), 64'(6 * (W/2) * (H/2)));
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
